// File: rtl/trigger_conditioner.sv
// +----------------------------------------------------------------------------+
// | Module      : trigger_conditioner                                          |
// | Description : Synchronises and debounces a front-panel button and issues   |
// |               one active-low trigger per accepted press, with hold-off,    |
// |               latched duration and zero-duration rejection.                |
// |               Optional macro TRIG_COUNT_EN builds the accepted-trigger     |
// |               counter; otherwise trig_count is tied to zero.               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module trigger_conditioner #(
    parameter int DEB_CYCLES     = 50000,
    parameter int HOLDOFF_CYCLES = 1000
) (
    input  logic        clk_Trig,
    input  logic        rst,
    input  logic        button_n,
    input  logic [7:0]  duration_in,
    input  logic        pulse_active,
    output logic        trig_n,
    output logic [7:0]  duration,
    output logic        armed,
    output logic        err_zero,
    output logic [15:0] trig_count
);

    // Widths stay at least one bit so a parameter of 1 still yields a legal counter.
    localparam int c_DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int c_HO_W  = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [c_HO_W-1:0]  c_HO_LAST  = c_HO_W'(HOLDOFF_CYCLES - 1);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_DEBOUNCE = 3'd1;
    localparam logic [2:0] c_S_FIRE     = 3'd2;
    localparam logic [2:0] c_S_HOLDOFF  = 3'd3;
    localparam logic [2:0] c_S_WAIT_REL = 3'd4;

    logic [2:0]         r_state;
    logic               r_sync1;
    logic               r_sync2;
    logic [c_DEB_W-1:0] r_deb_cnt;
    logic [c_HO_W-1:0]  r_ho_cnt;
    logic               r_trig_n;
    logic [7:0]         r_duration;
    logic               r_armed;
    logic               r_err_zero;
    logic               w_b_s;

    assign w_b_s = r_sync2;

    always_ff @(posedge clk_Trig) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_state    <= c_S_IDLE;
            r_deb_cnt  <= '0;
            r_ho_cnt   <= '0;
            r_trig_n   <= 1'b1;
            r_duration <= 8'd0;
            r_armed    <= 1'b1;
            r_err_zero <= 1'b0;
        end else begin
            r_sync1    <= button_n;
            r_sync2    <= r_sync1;
            r_trig_n   <= 1'b1;
            r_err_zero <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    r_armed <= 1'b1;
                    if (!w_b_s) begin
                        r_state   <= c_S_DEBOUNCE;
                        r_deb_cnt <= '0;
                    end
                end
                c_S_DEBOUNCE: begin
                    if (w_b_s) begin
                        r_state <= c_S_IDLE;
                    end else if (r_deb_cnt == c_DEB_LAST) begin
                        if (duration_in != 8'd0) begin
                            r_state    <= c_S_FIRE;
                            r_duration <= duration_in;
                            r_trig_n   <= 1'b0;
                        end else begin
                            r_state    <= c_S_WAIT_REL;
                            r_err_zero <= 1'b1;
                            r_armed    <= 1'b0;
                            r_deb_cnt  <= '0;
                        end
                    end else begin
                        r_deb_cnt <= r_deb_cnt + c_DEB_W'(1);
                    end
                end
                c_S_FIRE: begin
                    r_state  <= c_S_HOLDOFF;
                    r_ho_cnt <= '0;
                    r_armed  <= 1'b0;
                end
                c_S_HOLDOFF: begin
                    // The downstream pulse must also have finished before release tracking starts.
                    if ((r_ho_cnt == c_HO_LAST) && !pulse_active) begin
                        r_state   <= c_S_WAIT_REL;
                        r_deb_cnt <= '0;
                    end else if (r_ho_cnt != c_HO_LAST) begin
                        r_ho_cnt <= r_ho_cnt + c_HO_W'(1);
                    end
                end
                c_S_WAIT_REL: begin
                    if (!w_b_s) begin
                        r_deb_cnt <= '0;
                    end else if (r_deb_cnt == c_DEB_LAST) begin
                        r_state <= c_S_IDLE;
                        r_armed <= 1'b1;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + c_DEB_W'(1);
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_armed <= 1'b1;
                end
            endcase
        end
    end

    assign trig_n   = r_trig_n;
    assign duration = r_duration;
    assign armed    = r_armed;
    assign err_zero = r_err_zero;

`ifdef TRIG_COUNT_EN
    logic [15:0] r_trig_count;

    // FIRE lasts exactly one cycle, so counting while in it counts each entry once.
    always_ff @(posedge clk_Trig) begin
        if (rst) begin
            r_trig_count <= 16'd0;
        end else if ((r_state == c_S_FIRE) && (r_trig_count != 16'hFFFF)) begin
            r_trig_count <= r_trig_count + 16'd1;
        end
    end

    assign trig_count = r_trig_count;
`else
    assign trig_count = 16'd0;
`endif

endmodule

`default_nettype wire
